// File: rtl/ren_simd_arbiter.sv
// rtl/ren_simd_arbiter.sv - round-robin arbiter sequencing one FP_SIMD operation per grant
// Optional abort-on-timeout in S_WAIT is enabled by defining REN_SIMD_ARB_TIMEOUT_EN.
module ren_simd_arbiter #(
    parameter int NREQ    = 2,
    parameter int LANES   = 4,
    parameter int TIMEOUT = 64,
    parameter int W       = 22 * LANES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     i_req,
    input  logic [NREQ*W-1:0]   i_in0,
    input  logic [NREQ*W-1:0]   i_in1,
    input  logic [NREQ*3-1:0]   i_opcode,
    output logic [NREQ-1:0]     o_gnt,
    output logic [NREQ-1:0]     o_valid,
    output logic [W-1:0]        o_result,
    output logic                o_err,
    output logic                o_simd_en,
    output logic [W-1:0]        o_simd_in0,
    output logic [W-1:0]        o_simd_in1,
    output logic [2:0]          o_simd_opcode,
    input  logic [W-1:0]        i_simd_out,
    input  logic                i_simd_valid,
    input  logic                i_simd_busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
        $error("ren_simd_arbiter: unsupported NREQ/TIMEOUT");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    logic [IW-1:0]   r_idx;
    logic [IW-1:0]   r_last;
    logic            pick_found;
    logic [IW-1:0]   pick_idx;

`ifdef REN_SIMD_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]   wait_cnt;
`endif

    // Round-robin search starting one past the last serviced requester.
    always_comb begin : arb_search
        int cand;
        cand       = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = (int'(r_last) + i) % NREQ;
            if (!pick_found && i_req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = IW'(cand);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            r_idx         <= '0;
            r_last        <= '0;
            o_gnt         <= '0;
            o_valid       <= '0;
            o_result      <= '0;
            o_err         <= 1'b0;
            o_simd_en     <= 1'b0;
            o_simd_in0    <= '0;
            o_simd_in1    <= '0;
            o_simd_opcode <= '0;
`ifdef REN_SIMD_ARB_TIMEOUT_EN
            wait_cnt      <= '0;
`endif
        end else begin
            o_valid <= '0;
            o_err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pick_found && !i_simd_busy) begin
                        r_idx         <= pick_idx;
                        o_gnt         <= ONE << pick_idx;
                        o_simd_in0    <= i_in0[pick_idx*W +: W];
                        o_simd_in1    <= i_in1[pick_idx*W +: W];
                        o_simd_opcode <= i_opcode[pick_idx*3 +: 3];
                        o_simd_en     <= 1'b1;
                        state         <= S_WAIT;
`ifdef REN_SIMD_ARB_TIMEOUT_EN
                        wait_cnt      <= '0;
`endif
                    end
                end
                S_WAIT: begin
                    if (i_simd_valid) begin
                        o_result  <= i_simd_out;
                        o_valid   <= ONE << r_idx;
                        o_simd_en <= 1'b0;
                        r_last    <= r_idx;
                        state     <= S_DONE;
                    end
`ifdef REN_SIMD_ARB_TIMEOUT_EN
                    // A valid arriving on the expiry cycle takes priority over the abort.
                    else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                        o_result  <= '0;
                        o_valid   <= ONE << r_idx;
                        o_err     <= 1'b1;
                        o_simd_en <= 1'b0;
                        r_last    <= r_idx;
                        state     <= S_DONE;
                    end else begin
                        wait_cnt  <= wait_cnt + 1'b1;
                    end
`endif
                end
                S_DONE: begin
                    // One cycle with the enable low lets the SIMD unit re-arm.
                    o_gnt     <= '0;
                    o_simd_en <= 1'b0;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ren_simd_arbiter.sv
// tb/tb_ren_simd_arbiter.sv - directed self-checking bench for ren_simd_arbiter
// Covers the timeout path when REN_SIMD_ARB_TIMEOUT_EN is defined.
module tb_ren_simd_arbiter;

    localparam int NREQ    = 2;
    localparam int LANES   = 4;
    localparam int TIMEOUT = 8;
    localparam int W       = 22 * LANES;

    // fp22 encoding used here: sign, 6-bit exponent (bias 31), 15-bit mantissa
    localparam logic [21:0] FP1 = 22'h0F8000;
    localparam logic [21:0] FP2 = 22'h100000;
    localparam logic [21:0] FP3 = 22'h104000;
    localparam logic [W-1:0] FP1X4 = {4{FP1}};
    localparam logic [W-1:0] FP2X4 = {4{FP2}};
    localparam logic [W-1:0] FP3X4 = {4{FP3}};
    localparam logic [W-1:0] VA = 88'h11_2233_4455_6677_8899_aabb;
    localparam logic [W-1:0] VB = 88'hcc_ddee_ff00_1122_3344_5566;
    localparam logic [W-1:0] VC = 88'h5a_5a5a_a5a5_0f0f_f0f0_1234;
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_MUL = 3'd1;
    localparam logic [2:0] OP_RCP = 3'd2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NREQ-1:0]     req = '0;
    logic [NREQ*W-1:0]   in0 = '0;
    logic [NREQ*W-1:0]   in1 = '0;
    logic [NREQ*3-1:0]   opcode = '0;
    logic [NREQ-1:0]     gnt;
    logic [NREQ-1:0]     valid;
    logic [W-1:0]        result;
    logic                err;
    logic                simd_en;
    logic [W-1:0]        simd_in0;
    logic [W-1:0]        simd_in1;
    logic [2:0]          simd_opcode;
    logic [W-1:0]        simd_out = '0;
    logic                simd_valid = 1'b0;
    logic                simd_busy = 1'b0;

    int checks = 0;
    int failures = 0;
    int multi_gnt = 0;

    ren_simd_arbiter #(.NREQ(NREQ), .LANES(LANES), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_req         (req),
        .i_in0         (in0),
        .i_in1         (in1),
        .i_opcode      (opcode),
        .o_gnt         (gnt),
        .o_valid       (valid),
        .o_result      (result),
        .o_err         (err),
        .o_simd_en     (simd_en),
        .o_simd_in0    (simd_in0),
        .o_simd_in1    (simd_in1),
        .o_simd_opcode (simd_opcode),
        .i_simd_out    (simd_out),
        .i_simd_valid  (simd_valid),
        .i_simd_busy   (simd_busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if ($countones(gnt) > 1) multi_gnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Returns the number of cycles until a grant appears (0 if none within budget).
    task automatic wait_gnt(output int n);
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (gnt != '0) begin
                n = i;
                break;
            end
        end
    endtask

    // SIMD model: called at the negedge where the enable is first seen.
    task automatic simd_respond(input int lat, input logic [W-1:0] res);
        for (int i = 1; i < lat; i++) tick();
        simd_out   = res;
        simd_valid = 1'b1;
        tick();
        simd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({gnt, valid, err, simd_en} !== '0) begin
            failures++;
            $display("FAIL reset_ctrl got gnt=%b valid=%b err=%b en=%b expected all 0", gnt, valid, err, simd_en);
        end
        checks++;
        if ({result, simd_in0, simd_in1, simd_opcode} !== '0) begin
            failures++;
            $display("FAIL reset_data got result=%h in0=%h op=%h expected 0", result, simd_in0, simd_opcode);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int n;
        in0[0 +: W] = FP1X4;
        in1[0 +: W] = FP2X4;
        opcode[2:0] = OP_ADD;
        req = 2'b01;
        wait_gnt(n);
        checks++;
        if (n != 1 || gnt !== 2'b01 || simd_en !== 1'b1) begin
            failures++;
            $display("FAIL single_gnt got n=%0d gnt=%b en=%b expected n=1 gnt=01 en=1", n, gnt, simd_en);
        end
        checks++;
        if (simd_in0 !== FP1X4 || simd_in1 !== FP2X4 || simd_opcode !== OP_ADD) begin
            failures++;
            $display("FAIL single_operands got in0=%h in1=%h op=%0d expected %h %h %0d",
                     simd_in0, simd_in1, simd_opcode, FP1X4, FP2X4, OP_ADD);
        end
        simd_respond(4, FP3X4);
        checks++;
        if (valid !== 2'b01 || result !== FP3X4 || err !== 1'b0) begin
            failures++;
            $display("FAIL single_result got valid=%b result=%h err=%b expected 01 %h 0", valid, result, err, FP3X4);
        end
        req = 2'b00;
        tick();
        checks++;
        if (valid !== 2'b00 || gnt !== 2'b00 || simd_en !== 1'b0 || result !== FP3X4) begin
            failures++;
            $display("FAIL single_after got valid=%b gnt=%b en=%b result=%h expected 00 00 0 %h",
                     valid, gnt, simd_en, result, FP3X4);
        end
        tick();
        tick();
    endtask

    task automatic test_contention();
        int n;
        logic [1:0] exp_g [3];
        exp_g[0] = 2'b10;
        exp_g[1] = 2'b01;
        exp_g[2] = 2'b10;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        multi_gnt = 0;
        in0 = {VB, VA};
        in1 = {VA, VB};
        opcode = {OP_MUL, OP_RCP};
        req = 2'b11;
        for (int k = 0; k < 3; k++) begin
            wait_gnt(n);
            checks++;
            if (gnt !== exp_g[k]) begin
                failures++;
                $display("FAIL contention_gnt%0d got %b expected %b", k, gnt, exp_g[k]);
            end
            checks++;
            if (simd_in0 !== (exp_g[k][1] ? VB : VA) || simd_opcode !== (exp_g[k][1] ? OP_MUL : OP_RCP)) begin
                failures++;
                $display("FAIL contention_mux%0d got in0=%h op=%0d", k, simd_in0, simd_opcode);
            end
            simd_respond(2, VC ^ W'(k));
            checks++;
            if (valid !== exp_g[k] || result !== (VC ^ W'(k))) begin
                failures++;
                $display("FAIL contention_valid%0d got valid=%b result=%h expected %b %h",
                         k, valid, result, exp_g[k], VC ^ W'(k));
            end
        end
        req = 2'b00;
        tick();
        tick();
        checks++;
        if (multi_gnt != 0) begin
            failures++;
            $display("FAIL contention_onehot got %0d multi-bit grant cycles expected 0", multi_gnt);
        end
    endtask

    task automatic test_busy();
        int bad;
        bad = 0;
        simd_busy = 1'b1;
        in0[0 +: W] = VA;
        req = 2'b01;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (gnt !== 2'b00 || simd_en !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL busy_block got %0d granted cycles expected 0", bad);
        end
        simd_busy = 1'b0;
        tick();
        checks++;
        if (gnt !== 2'b01 || simd_in0 !== VA) begin
            failures++;
            $display("FAIL busy_release got gnt=%b in0=%h expected 01 %h", gnt, simd_in0, VA);
        end
        simd_respond(3, VB);
        checks++;
        if (valid !== 2'b01 || result !== VB) begin
            failures++;
            $display("FAIL busy_result got valid=%b result=%h expected 01 %h", valid, result, VB);
        end
        req = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_reset_midop();
        int n;
        int bad;
        bad = 0;
        req = 2'b10;
        wait_gnt(n);
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (simd_en !== 1'b0 || gnt !== 2'b00 || result !== '0) begin
            failures++;
            $display("FAIL midop_reset got en=%b gnt=%b result=%h expected 0 00 0", simd_en, gnt, result);
        end
        req = 2'b00;
        tick();
        rst = 1'b0;
        tick();
        simd_out   = VC;
        simd_valid = 1'b1;
        tick();
        simd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (valid !== 2'b00 || result !== '0) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL midop_late_valid got %0d cycles with output activity expected 0", bad);
        end
    endtask

    task automatic test_req_drop();
        int n;
        in0 = {VA, VB};
        req = 2'b10;
        wait_gnt(n);
        checks++;
        if (gnt !== 2'b10) begin
            failures++;
            $display("FAIL drop_gnt got %b expected 10", gnt);
        end
        tick();
        req = 2'b01;
        simd_respond(3, VC);
        checks++;
        if (valid !== 2'b10 || result !== VC) begin
            failures++;
            $display("FAIL drop_valid got valid=%b result=%h expected 10 %h", valid, result, VC);
        end
        wait_gnt(n);
        checks++;
        if (gnt !== 2'b01 || simd_in0 !== VB) begin
            failures++;
            $display("FAIL drop_next got gnt=%b in0=%h expected 01 %h", gnt, simd_in0, VB);
        end
        simd_respond(2, VA);
        checks++;
        if (valid !== 2'b01 || result !== VA) begin
            failures++;
            $display("FAIL drop_next_valid got valid=%b result=%h expected 01 %h", valid, result, VA);
        end
        req = 2'b00;
        tick();
        tick();
    endtask

`ifdef REN_SIMD_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        int bad;
        bad = 0;
        req = 2'b01;
        wait_gnt(n);
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            tick();
            if (valid !== 2'b00 || simd_en !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL timeout_early got %0d early aborts expected 0", bad);
        end
        tick();
        checks++;
        if (valid !== 2'b01 || err !== 1'b1 || result !== '0 || simd_en !== 1'b0) begin
            failures++;
            $display("FAIL timeout_abort got valid=%b err=%b result=%h en=%b expected 01 1 0 0",
                     valid, err, result, simd_en);
        end
        req = 2'b00;
        tick();
        checks++;
        if (err !== 1'b0 || valid !== 2'b00) begin
            failures++;
            $display("FAIL timeout_pulse got err=%b valid=%b expected 0 00", err, valid);
        end
        tick();
        req = 2'b01;
        wait_gnt(n);
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        simd_respond(1, VB);
        checks++;
        if (valid !== 2'b01 || err !== 1'b0 || result !== VB) begin
            failures++;
            $display("FAIL timeout_race got valid=%b err=%b result=%h expected 01 0 %h", valid, err, result, VB);
        end
        req = 2'b00;
        tick();
        tick();
    endtask
`else
    task automatic test_no_timeout();
        int n;
        int bad;
        bad = 0;
        req = 2'b01;
        wait_gnt(n);
        for (int i = 0; i < 3 * TIMEOUT; i++) begin
            tick();
            if (valid !== 2'b00 || err !== 1'b0 || simd_en !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL no_timeout_wait got %0d abort cycles expected 0", bad);
        end
        simd_respond(1, VC);
        checks++;
        if (valid !== 2'b01 || err !== 1'b0 || result !== VC) begin
            failures++;
            $display("FAIL no_timeout_result got valid=%b err=%b result=%h expected 01 0 %h", valid, err, result, VC);
        end
        req = 2'b00;
        tick();
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_busy();
        test_reset_midop();
        test_req_drop();
`ifdef REN_SIMD_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
